avg_pool_decimate: RTL and testbench
====================================

# avg_pool_decimate

Downstream averaging and decimation stage for the moving-sum accumulator in the 1D CNN pooling path. Consumes the running window sum of POOL_SIZE samples, divides it by POOL_SIZE with a rounded reciprocal multiply, and saturates the result back to the sample width. Discards the partial-window warm-up beats and forwards only every STRIDE-th full-window beat. Valid/ready handshakes on both sides, with a 2-stage stallable pipeline.

## Interface
- IN_WIDTH, 16, width of incoming window sum (sample width + clog2(POOL_SIZE)).
- OUT_WIDTH, 12, width of averaged output sample.
- POOL_SIZE, 10, window length the upstream sum covers.
- STRIDE, 10, decimation factor: one output per STRIDE eligible input beats (≥1).
- SKIP, 9, number of accepted input beats discarded after reset (partial windows, 0 allowed).
- RECIP_WIDTH, 16, fractional bits of reciprocal; RECIP = round(2^RECIP_WIDTH / POOL_SIZE), 6554 at defaults (localparam).

Ports:
- Reset: rst, synchronous, active-high. Clock: clk.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pool_ready_in  out  1  stage can accept an input beat.
- pool_valid_in  in  1  input beat valid.
- pool_data_in  in  IN_WIDTH  unsigned window sum.
- pool_ready_out  in  1  downstream accepts output beat.
- pool_valid_out  out  1  output beat valid.
- pool_data_out  out  OUT_WIDTH  unsigned averaged, saturated sample.
- pool_warm  out  1  high once SKIP beats have been discarded.

## Operation
- Input beat accepted when pool_valid_in & pool_ready_in. Counters advance only on accepted beats; idle cycles and valid gaps change nothing.
- skip_cnt (clog2(SKIP+1) bits): while skip_cnt < SKIP, each accepted beat is consumed and dropped, and skip_cnt increments. pool_warm = (skip_cnt == SKIP). With SKIP=0, pool_warm is high out of reset.
- phase_cnt (0..STRIDE-1): advances on each accepted beat while warm and wraps STRIDE-1→0. A beat is forwarded only when phase_cnt == 0. Non-forwarded beats are consumed and dropped.
- Stage 1: for a forwarded beat, register prod = pool_data_in * RECIP (IN_WIDTH+RECIP_WIDTH bits, unsigned) and set v1=1. Otherwise set v1=0.
- Stage 2: q = (prod + 2^(RECIP_WIDTH-1)) >> RECIP_WIDTH (round half up, no overflow at full width). pool_data_out = (q > 2^OUT_WIDTH-1) ? all-ones : q[OUT_WIDTH-1:0]. pool_valid_out <= v1.
- Pipeline enable: en = pool_ready_out | ~pool_valid_out. Both stages and both counters update only when en. pool_ready_in = en (combinational).
- Dropped beats still require en, so the input is never accepted while the output stalls.

## Timing
- Reset values: pool_valid_out=0, pool_data_out=0, v1=0, prod=0, skip_cnt=0, phase_cnt=0. pool_ready_in=1 in the first cycle after reset. pool_warm=(SKIP==0).
- Latency: a beat forwarded in cycle N gives pool_valid_out=1 at N+2 when no stall occurs. Throughput: 1 beat/cycle.
- Stall: while pool_valid_out=1 and pool_ready_out=0, pool_data_out, pool_valid_out, v1, prod and the counters are frozen, and pool_ready_in=0.
- Output handshake and a new input beat in the same cycle: both complete and the pipeline shifts.
- Reset asserted mid-operation: in-flight beats are discarded, the counters clear, and the SKIP warm-up restarts.
- Saturation is the only clipping. At defaults the maximum legal sum, 40950, yields 4095 without clipping.

## Test plan
- SKIP=0, STRIDE=1, continuous valid, pool_ready_out=1, inputs 40950, 0, 15 -> outputs 4095, 0, 2 at cycles 2, 3, 4; pool_warm=1 throughout.
- Defaults, beat k carries 100*k for k=0..29, no stalls -> beats 0..8 dropped; pool_warm rises after beat 8. Outputs 90, 190, 290 (beats 9, 19, 29), each 2 cycles after acceptance. No other output beats.
- Defaults with random pool_valid_in gaps, same data as the previous scenario -> identical output sequence 90, 190, 290.
- Backpressure: output valid with 90, pool_ready_out held low 5 cycles -> pool_data_out stays 90, pool_ready_in=0, counters frozen. After release, no input beat is lost or duplicated.
- Saturation, SKIP=0, STRIDE=1: input 65535 -> output 4095. Input 40955 -> 4095 (rounding edge). Input 5 -> 1 (0.5 rounds up).
- Reset after 5 accepted beats at defaults -> valid_out=0 next cycle and pool_warm=0. The next 9 beats are dropped and the 10th is forwarded.

Source files
------------

// File: rtl/avg_pool_decimate.sv
// Window-sum averaging and decimation stage for the 1D CNN pooling path.
// Divides by POOL_SIZE via rounded reciprocal multiply, saturates, decimates.
module avg_pool_decimate #(
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 12,
  parameter int POOL_SIZE   = 10,
  parameter int STRIDE      = 10,
  parameter int SKIP        = 9,
  parameter int RECIP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 pool_ready_in,
  input  logic                 pool_valid_in,
  input  logic [IN_WIDTH-1:0]  pool_data_in,
  input  logic                 pool_ready_out,
  output logic                 pool_valid_out,
  output logic [OUT_WIDTH-1:0] pool_data_out,
  output logic                 pool_warm
);

  localparam int PW  = IN_WIDTH + RECIP_WIDTH;
  localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int PHW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam longint unsigned RECIP_L =
    ((64'd1 << RECIP_WIDTH) + 64'(POOL_SIZE / 2)) / 64'(POOL_SIZE);
  localparam logic [PW-1:0] RECIP = PW'(RECIP_L);

  localparam logic [PW:0] HALF = (PW+1)'(1) << (RECIP_WIDTH - 1);
  localparam logic [PW:0] MAXV = (PW+1)'((64'd1 << OUT_WIDTH) - 64'd1);

  logic [SKW-1:0] skip_cnt;
  logic [PHW-1:0] phase_cnt;
  logic           v1;
  logic [PW-1:0]  prod;

  logic           en;
  logic           accept;
  logic           fwd;
  logic [PW-1:0]  mult;
  logic [PW:0]    rsum;
  logic [PW:0]    q;
  logic           sat;

  // Handshake, forwarding decision and the arithmetic datapath.
  always_comb begin
    en            = pool_ready_out | ~pool_valid_out;
    pool_ready_in = en;
    pool_warm     = (skip_cnt == SKW'(SKIP));
    accept        = pool_valid_in & en;
    fwd           = accept & pool_warm & (phase_cnt == '0);
    mult          = PW'(pool_data_in) * RECIP;
    rsum          = {1'b0, prod} + HALF;
    q             = rsum >> RECIP_WIDTH;
    sat           = (q > MAXV);
  end

  // Warm-up and decimation counters, advancing only on accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      skip_cnt  <= '0;
      phase_cnt <= '0;
    end else if (accept) begin
      if (!pool_warm) begin
        skip_cnt <= skip_cnt + 1'b1;
      end else if (phase_cnt == PHW'(STRIDE - 1)) begin
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + 1'b1;
      end
    end
  end

  // Stage 1: reciprocal multiply of the forwarded beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      prod <= '0;
    end else if (en) begin
      v1 <= fwd;
      if (fwd) begin
        prod <= mult;
      end
    end
  end

  // Stage 2: round half up, saturate to the sample width.
  always_ff @(posedge clk) begin
    if (rst) begin
      pool_valid_out <= 1'b0;
      pool_data_out  <= '0;
    end else if (en) begin
      pool_valid_out <= v1;
      pool_data_out  <= sat ? '1 : q[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_avg_pool_decimate.sv
// Directed bench for avg_pool_decimate: default instance plus a
// SKIP=0/STRIDE=1 instance for the arithmetic edge cases.
module tb_avg_pool_decimate;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_rdy_in, a_vin, a_rout, a_vout, a_warm;
  logic [15:0] a_din;
  logic [11:0] a_dout;
  logic        b_rdy_in, b_vin, b_rout, b_vout, b_warm;
  logic [15:0] b_din;
  logic [11:0] b_dout;

  avg_pool_decimate dut_a (
    .clk(clk), .rst(rst),
    .pool_ready_in(a_rdy_in), .pool_valid_in(a_vin),
    .pool_data_in(a_din), .pool_ready_out(a_rout),
    .pool_valid_out(a_vout), .pool_data_out(a_dout),
    .pool_warm(a_warm)
  );

  avg_pool_decimate #(.STRIDE(1), .SKIP(0)) dut_b (
    .clk(clk), .rst(rst),
    .pool_ready_in(b_rdy_in), .pool_valid_in(b_vin),
    .pool_data_in(b_din), .pool_ready_out(b_rout),
    .pool_valid_out(b_vout), .pool_data_out(b_dout),
    .pool_warm(b_warm)
  );

  typedef struct {
    logic [15:0] din;
    int          exp;
  } vec_t;

  vec_t tbl [6];
  int   nvec = 0;
  int   nerr = 0;

  int cyc = 0;
  int a_acc = 0;
  int a_acc_cyc [128];
  int a_out [$];
  int a_out_cyc [$];
  int b_acc_cyc [$];
  int b_out [$];
  int b_out_cyc [$];
  int b_warm_low = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!b_warm) b_warm_low++;
      if (rst) begin
        a_acc = 0;
        a_out.delete();
        a_out_cyc.delete();
        b_acc_cyc.delete();
        b_out.delete();
        b_out_cyc.delete();
      end else begin
        if (a_vin && a_rdy_in) begin
          if (a_acc < 128) a_acc_cyc[a_acc] = cyc;
          a_acc++;
        end
        if (a_vout && a_rout) begin
          a_out.push_back(int'(a_dout));
          a_out_cyc.push_back(cyc);
        end
        if (b_vin && b_rdy_in) b_acc_cyc.push_back(cyc);
        if (b_vout && b_rout) begin
          b_out.push_back(int'(b_dout));
          b_out_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst   = 1'b1;
    a_vin = 1'b0;
    b_vin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_a(input logic [15:0] d);
    bit ok;
    ok    = 1'b0;
    a_vin = 1'b1;
    a_din = d;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = a_rdy_in;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send timeout", 0, 1);
  endtask

  task automatic check_a_seq(input string name, input bit lat);
    chk({name, " count"}, a_out.size(), 3);
    for (int j = 0; j < 3 && j < a_out.size(); j++) begin
      chk({name, " data"}, a_out[j], 90 + 100 * j);
      if (lat) chk({name, " latency"}, a_out_cyc[j] - a_acc_cyc[9 + 10 * j], 2);
    end
  endtask

  initial begin
    tbl[0] = '{16'd40950, 4095};
    tbl[1] = '{16'd0,     0};
    tbl[2] = '{16'd15,    2};
    tbl[3] = '{16'd65535, 4095};
    tbl[4] = '{16'd40955, 4095};
    tbl[5] = '{16'd5,     1};

    a_rout = 1'b1;
    b_rout = 1'b1;
    a_din  = '0;
    b_din  = '0;
    do_reset();

    @(negedge clk);
    chk("reset a_vout", int'(a_vout), 0);
    chk("reset a_dout", int'(a_dout), 0);
    chk("reset a_rdy_in", int'(a_rdy_in), 1);
    chk("reset a_warm", int'(a_warm), 0);
    chk("reset b_warm", int'(b_warm), 1);
    chk("reset b_vout", int'(b_vout), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      b_vin = 1'b1;
      b_din = tbl[i].din;
      @(posedge clk);
      #1;
    end
    b_vin = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("tbl count", b_out.size(), 6);
    for (int i = 0; i < 6 && i < b_out.size(); i++) begin
      chk($sformatf("tbl data %0d", i), b_out[i], tbl[i].exp);
      chk($sformatf("tbl lat %0d", i), b_out_cyc[i] - b_acc_cyc[i], 2);
    end
    chk("b warm low cycles", b_warm_low, 0);

    do_reset();
    for (int k = 0; k < 30; k++) begin
      send_a(16'(100 * k));
      if (k == 7) chk("warm after beat 7", int'(a_warm), 0);
      if (k == 8) chk("warm after beat 8", int'(a_warm), 1);
    end
    a_vin = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_a_seq("stream", 1'b1);

    do_reset();
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        a_vin = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_a(16'(100 * k));
    end
    a_vin = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_a_seq("gaps", 1'b1);

    do_reset();
    a_rout = 1'b0;
    fork
      begin
        for (int k = 0; k < 30; k++) send_a(16'(100 * k));
        a_vin = 1'b0;
      end
      begin
        for (int w = 0; w < 100; w++) begin
          @(negedge clk);
          if (a_vout) break;
        end
        chk("bp valid seen", int'(a_vout), 1);
        for (int s = 0; s < 5; s++) begin
          if (s > 0) @(negedge clk);
          chk("bp hold data", int'(a_dout), 90);
          chk("bp hold valid", int'(a_vout), 1);
          chk("bp ready_in low", int'(a_rdy_in), 0);
        end
        @(posedge clk);
        #1;
        a_rout = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    check_a_seq("backpressure", 1'b0);

    do_reset();
    for (int k = 0; k < 5; k++) send_a(16'(1000 + k));
    a_vin = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid reset vout", int'(a_vout), 0);
    chk("mid reset warm", int'(a_warm), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      send_a(16'(100 * k));
      if (k == 8) chk("rewarm after beat 8", int'(a_warm), 1);
    end
    a_vin = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid reset count", a_out.size(), 1);
    if (a_out.size() > 0) chk("mid reset data", a_out[0], 90);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
